// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and frame helpers used by
// uart_rx and uart_tx.
package uart_pkg;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE       = 3'd0;
    localparam uart_state_t ST_START_BIT  = 3'd1;
    localparam uart_state_t ST_DATA_BITS  = 3'd2;
    localparam uart_state_t ST_PARITY_BIT = 3'd3;
    localparam uart_state_t ST_STOP_BIT   = 3'd4;
    localparam uart_state_t ST_WAIT_IDLE  = 3'd5;
    localparam uart_state_t ST_CLEANUP    = 3'd6;

    localparam logic [2:0] LAST_DATA_BIT = 3'd7;

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input, with a
// parameterised value loaded while reset is held.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            meta     <= RESET_VAL;
            sync_out <= RESET_VAL;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits, 1 stop bit, LSB first, centre sampling.
// Define UART_RX_PARITY_EN to receive one even-parity bit after the data.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Rx_Frame_Err,
    output logic       o_Rx_Parity_Err
);

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] MID_LAST = 16'((CLKS_PER_BIT - 1) / 2);

    uart_state_t state;
    uart_state_t state_next;
    logic [15:0] clk_count;
    logic [2:0]  bit_index;
    logic [7:0]  rx_shift;
    logic        rx_sync;
    logic        bit_done;
    logic        mid_start;

    uart_sync2 #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .async_in(i_Rx_Serial),
        .sync_out(rx_sync)
    );

    assign bit_done  = (clk_count == BIT_LAST);
    assign mid_start = (clk_count == MID_LAST);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (!rx_sync) begin
                    state_next = ST_START_BIT;
                end
            end
            ST_START_BIT: begin
                // A line that is high again at mid-start was only a glitch.
                if (mid_start) begin
                    state_next = rx_sync ? ST_IDLE : ST_DATA_BITS;
                end
            end
            ST_DATA_BITS: begin
                if (bit_done && (bit_index == LAST_DATA_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    state_next = ST_PARITY_BIT;
`else
                    state_next = ST_STOP_BIT;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY_BIT: begin
                if (bit_done) begin
                    state_next = ST_STOP_BIT;
                end
            end
`endif
            ST_STOP_BIT: begin
                if (bit_done) begin
                    state_next = rx_sync ? ST_CLEANUP : ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_sync) begin
                    state_next = ST_CLEANUP;
                end
            end
            ST_CLEANUP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic parity_bad;
    logic parity_err_q;

    assign o_Rx_Parity_Err = parity_err_q;
`else
    assign o_Rx_Parity_Err = 1'b0;
`endif

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            clk_count      <= 16'd0;
            bit_index      <= 3'd0;
            rx_shift       <= 8'h00;
            o_Rx_Byte      <= 8'h00;
            o_Rx_DV        <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad     <= 1'b0;
            parity_err_q   <= 1'b0;
`endif
        end else begin
            o_Rx_DV        <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q   <= 1'b0;
`endif
            case (state)
                ST_START_BIT: begin
                    clk_count <= mid_start ? 16'd0 : clk_count + 16'd1;
                end
                ST_DATA_BITS: begin
                    if (bit_done) begin
                        clk_count           <= 16'd0;
                        rx_shift[bit_index] <= rx_sync;
                        bit_index <= (bit_index == LAST_DATA_BIT) ? 3'd0 : bit_index + 3'd1;
                    end else begin
                        clk_count <= clk_count + 16'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY_BIT: begin
                    if (bit_done) begin
                        clk_count  <= 16'd0;
                        parity_bad <= (even_parity(rx_shift) != rx_sync);
                    end else begin
                        clk_count <= clk_count + 16'd1;
                    end
                end
`endif
                ST_STOP_BIT: begin
                    if (bit_done) begin
                        clk_count <= 16'd0;
                        // A low stop bit wins over any parity verdict.
                        if (!rx_sync) begin
                            o_Rx_Frame_Err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (parity_bad) begin
                            parity_err_q <= 1'b1;
`endif
                        end else begin
                            o_Rx_Byte <= rx_shift;
                            o_Rx_DV   <= 1'b1;
                        end
                    end else begin
                        clk_count <= clk_count + 16'd1;
                    end
                end
                default: begin
                    clk_count <= 16'd0;
                    bit_index <= 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        o_Rx_Active = 1'b0;
        case (state)
            ST_DATA_BITS, ST_PARITY_BIT, ST_STOP_BIT, ST_WAIT_IDLE: o_Rx_Active = 1'b1;
            default: o_Rx_Active = 1'b0;
        endcase
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, clock cycles per UART bit (i_Clock freq / baud); legal range 4..65535.
REQ-002 SHALL have port i_Clock  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port i_Reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_Rx_Serial  input  1  asynchronous serial line; idle high.
REQ-005 SHALL have port o_Rx_DV  output  1  one-cycle pulse: o_Rx_Byte holds a new valid byte.
REQ-006 SHALL have port o_Rx_Byte  output  8  last good received byte; held between pulses.
REQ-007 SHALL have port o_Rx_Active  output  1  high from accepted start bit until frame end.
REQ-008 SHALL have port o_Rx_Frame_Err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port o_Rx_Parity_Err  output  1  one-cycle pulse: parity mismatch (see Configuration).

Function
REQ-010 SHALL pass i_Rx_Serial through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-011 SHALL implement states IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT, WAIT_IDLE, CLEANUP.
REQ-012 IDLE: clear counters; on synchronized line low go to START_BIT.
REQ-013 START_BIT: at count (CLKS_PER_BIT-1)/2, if line low assert o_Rx_Active, zero counter, go to DATA_BITS; if line high (glitch) return to IDLE with no output.
REQ-014 DATA_BITS: sample every CLKS_PER_BIT cycles after the mid-start sample, LSB first, into 8-bit shift register; after bit 7 go to PARITY_BIT (macro on) or STOP_BIT.
REQ-015 STOP_BIT: sample CLKS_PER_BIT cycles after the last sample; high -> load o_Rx_Byte, pulse o_Rx_DV next cycle, go to CLEANUP; low -> pulse o_Rx_Frame_Err, o_Rx_Byte unchanged, go to WAIT_IDLE.
REQ-016 WAIT_IDLE: stay until synchronized line high (break/stuck-low), then CLEANUP; no new start detected here.
REQ-017 CLEANUP: one cycle, deassert o_Rx_Active, go to IDLE.
REQ-018 o_Rx_DV, o_Rx_Frame_Err, o_Rx_Parity_Err SHALL each be high for exactly one cycle and never simultaneously with o_Rx_DV.
REQ-019 Latency: o_Rx_DV SHALL assert 1 cycle after the stop-bit mid sample (plus 2-cycle synchronizer delay from pin).
REQ-020 Clock counter SHALL be 16 bits, comparisons against CLKS_PER_BIT-1; bit index 3 bits, no wrap beyond 7.
REQ-021 Back-to-back frames (start bit immediately after stop bit) SHALL be received without loss.

Reset
REQ-022 While i_Reset high: state IDLE, counters 0, synchronizer flops 1, o_Rx_Byte 8'h00, all pulses and o_Rx_Active 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no DV/error pulse; reception restarts on next falling edge after release.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: PARITY_BIT state active, one even-parity bit after data, sampled mid-bit; mismatch -> pulse o_Rx_Parity_Err at frame end instead of o_Rx_DV, o_Rx_Byte unchanged; framing error takes precedence.
REQ-025 Macro undefined: PARITY_BIT state unreachable/absent, 8N1 only, o_Rx_Parity_Err tied 0.

Structure
REQ-026 State encodings (3-bit localparams) SHALL live in shared package uart_pkg, also used by uart_tx.
REQ-027 Synchronizer SHALL be a separate sub-module uart_sync2 (parameterised reset value); rest flat.

Verification (CLKS_PER_BIT=16 unless stated)
REQ-028 Frame 0xA5, valid stop -> o_Rx_Byte=8'hA5, o_Rx_DV one cycle, no errors.
REQ-029 Low glitch of 4 cycles on idle line -> return to IDLE, o_Rx_Active never high, no pulses.
REQ-030 Frame 0x3C with stop bit low, line held low 100 cycles -> one o_Rx_Frame_Err pulse, byte stays previous, next frame 0x81 received correctly.
REQ-031 Back-to-back 0x00, 0xFF, 0x55 -> three DV pulses with matching bytes in order.
REQ-032 i_Reset pulse at data bit 4 of 0x7E -> no pulses, outputs reset values; following 0x12 received.
REQ-033 UART_RX_PARITY_EN: 0x07 with parity 0 -> o_Rx_Parity_Err pulse, no DV; with parity 1 -> DV, byte 8'h07.
